// File: rtl/td4_datapath_if.sv
// td4_datapath_if: decoder/ROM/IO bundle between the TD4 control side and its datapath
interface td4_datapath_if #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 4
);
    logic                   step;
    logic [OP_W+DATA_W-1:0] instr;
    logic [DATA_W-1:0]      in_port;
    logic [1:0]             sel;
    logic [3:0]             ld;
    logic [OP_W-1:0]        op;
    logic                   c;
    logic [DATA_W-1:0]      pc;
    logic [DATA_W-1:0]      out_port;
    logic [DATA_W-1:0]      reg_a;
    logic [DATA_W-1:0]      reg_b;

    modport master (
        output step, instr, in_port, sel, ld,
        input  op, c, pc, out_port, reg_a, reg_b
    );

    modport slave (
        input  step, instr, in_port, sel, ld,
        output op, c, pc, out_port, reg_a, reg_b
    );
endinterface

// File: rtl/td4_datapath.sv
// td4_datapath: TD4 execution stage with A/B/OUT/PC/C registers, source mux and immediate adder
module td4_datapath #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 4
) (
    input logic          clk,
    input logic          rst,
    td4_datapath_if.slave dp
);
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, o_q, o_d, pc_q, pc_d;
    logic              c_q, c_d;
    logic [DATA_W-1:0] src, im, sum;
    logic              cout;

    assign im          = dp.instr[DATA_W-1:0];
    assign dp.op       = dp.instr[OP_W+DATA_W-1:DATA_W];
    assign dp.c        = c_q;
    assign dp.pc       = pc_q;
    assign dp.out_port = o_q;
    assign dp.reg_a    = a_q;
    assign dp.reg_b    = b_q;

    // Source mux feeding the carry-producing immediate adder
    always_comb begin
        src = dp.sel == 2'b00 ? a_q :
              dp.sel == 2'b01 ? b_q :
              dp.sel == 2'b10 ? dp.in_port : '0;
        {cout, sum} = {1'b0, src} + {1'b0, im};
    end

    // Next state: a register loads only on a definite 0 strobe; X/Z/1 falls through to hold
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        o_d  = o_q;
        pc_d = pc_q + DATA_W'(1);
        c_d  = cout;
        if (dp.ld[0] == 1'b0) a_d = sum;
        if (dp.ld[1] == 1'b0) b_d = sum;
        if (dp.ld[2] == 1'b0) o_d = sum;
        if (dp.ld[3] == 1'b0) pc_d = sum;
    end

    // State update: reset wins over step, step gates every register including C
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            o_q  <= '0;
            pc_q <= '0;
            c_q  <= 1'b0;
        end else if (dp.step) begin
            a_q  <= a_d;
            b_q  <= b_d;
            o_q  <= o_d;
            pc_q <= pc_d;
            c_q  <= c_d;
        end
    end
endmodule

// File: tb/tb_td4_datapath.sv
// tb_td4_datapath: scoreboard bench for td4_datapath with directed and random instructions
module tb_td4_datapath;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    typedef struct {
        logic [3:0] a, b, o, p;
        logic       c;
    } st_t;

    st_t q[$];

    logic [3:0] m_reg[4];
    logic       m_c;

    td4_datapath_if #(.DATA_W(4), .OP_W(4)) dp ();

    td4_datapath dut (
        .clk (clk),
        .rst (rst),
        .dp  (dp.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at negedge, advance the model, queue the expected state
    task automatic drive(input bit r, input bit s, input logic [3:0] opc, input logic [3:0] im,
                         input logic [3:0] inp, input logic [1:0] sl, input logic [3:0] l);
        int src, tot;
        st_t e;
        @(negedge clk);
        rst        = r;
        dp.step    = s;
        dp.instr   = {opc, im};
        dp.in_port = inp;
        dp.sel     = sl;
        dp.ld      = l;
        if (r) begin
            foreach (m_reg[i]) m_reg[i] = 4'h0;
            m_c = 1'b0;
        end else if (s) begin
            case (sl)
                2'd0: src = int'(m_reg[0]);
                2'd1: src = int'(m_reg[1]);
                2'd2: src = int'(inp);
                default: src = 0;
            endcase
            tot = src + int'(im);
            m_reg[3] = 4'((m_reg[3] + 1) % 16);
            for (int i = 0; i < 4; i++) if (l[i] == 1'b0) m_reg[i] = 4'(tot % 16);
            m_c = tot > 15;
        end
        e.a = m_reg[0];
        e.b = m_reg[1];
        e.o = m_reg[2];
        e.p = m_reg[3];
        e.c = m_c;
        q.push_back(e);
        #1 chk("op", int'(dp.op), int'(opc));
    endtask

    // Monitor: after each edge, compare registered outputs to the oldest expectation
    always @(posedge clk) begin
        st_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("reg_a", int'(dp.reg_a), int'(e.a));
            chk("reg_b", int'(dp.reg_b), int'(e.b));
            chk("out_port", int'(dp.out_port), int'(e.o));
            chk("pc", int'(dp.pc), int'(e.p));
            chk("c", int'(dp.c), int'(e.c));
        end
    end

    logic [3:0] decoder_ld[5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};

    initial begin
        rst = 1'b1;
        dp.step = 1'b0;
        dp.instr = '0;
        dp.in_port = '0;
        dp.sel = 2'b11;
        dp.ld = 4'b1111;
        foreach (m_reg[i]) m_reg[i] = 4'h0;
        m_c = 1'b0;
        drive(1, 1, 4'h3, 4'h0, 4'h0, 2'b11, 4'b1111);
        drive(0, 1, 4'h3, 4'h5, 4'h0, 2'b11, 4'b1110);
        drive(0, 1, 4'h0, 4'h3, 4'h0, 2'b00, 4'b1110);
        drive(0, 1, 4'h3, 4'hE, 4'h0, 2'b11, 4'b1110);
        drive(0, 1, 4'h0, 4'h3, 4'h0, 2'b00, 4'b1110);
        drive(0, 1, 4'hE, 4'h7, 4'h0, 2'b11, 4'b1111);
        drive(0, 1, 4'hF, 4'h9, 4'h0, 2'b11, 4'b0111);
        drive(0, 1, 4'hF, 4'hF, 4'h0, 2'b11, 4'b0111);
        drive(0, 1, 4'hE, 4'h0, 4'h0, 2'b11, 4'b1111);
        drive(0, 1, 4'h6, 4'h0, 4'h6, 2'b10, 4'b1101);
        drive(0, 1, 4'h9, 4'h0, 4'h0, 2'b01, 4'b1011);
        drive(0, 1, 4'h3, 4'hC, 4'h0, 2'b11, 4'b1010);
        for (int i = 0; i < 3; i++) drive(0, 0, 4'h3, 4'hA, 4'h0, 2'b11, 4'b1110);
        drive(1, 0, 4'h3, 4'h0, 4'h0, 2'b11, 4'b1111);
        for (int i = 0; i < 400; i++) begin
            logic [3:0] l;
            l = $urandom_range(1) ? decoder_ld[$urandom_range(4)] : 4'($urandom);
            drive($urandom_range(99) < 3, $urandom_range(99) < 85, 4'($urandom), 4'($urandom),
                  4'($urandom), 2'($urandom), l);
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
